color_scan_scheduler: RTL

//  Sequences one full colour scan on the TCS3200-style colour sensor: selects each

---
 rtl/color_scan_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/color_scan_scheduler.sv
// Request-driven colour scan for a TCS3200-style sensor: steps through the red, blue,
// green and clear filters, lets each settle, counts cs_out rising edges per window.
module color_scan_scheduler #(
    parameter int WINDOW_CYC = 240,
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cs_out,
    output logic             S0,
    output logic             S1,
    output logic             S2,
    output logic             S3,
    output logic             OE,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             sat,
    output logic [2:0]       state_dbg_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SETTLE = 3'd2,
        COUNT  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int TMR_W = $clog2(WINDOW_CYC + SETTLE_CYC + 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WINDOW_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q;
    logic [1:0]       idx_q;
    logic [1:0]       sel_q;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] work_q;
    logic [CNT_W-1:0] work_d;
    logic             sat_work_q;
    logic             sat_q;
    logic             oe_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] res_q [4];
    logic             cs_rise;
    logic             ovf;

    // Filter select codes in scan order: red, blue, green, clear.
    function automatic logic [1:0] filt_code(input logic [1:0] idx);
        case (idx)
            2'd0:    filt_code = 2'b00;
            2'd1:    filt_code = 2'b01;
            2'd2:    filt_code = 2'b11;
            default: filt_code = 2'b10;
        endcase
    endfunction

    // sync_q[0] may go metastable; sync_q[1] is the first safe sample.
    assign cs_rise = sync_q[1] & ~sync_q[2];
    assign ovf     = cs_rise && (work_q == CNT_MAX);

    always_comb begin
        work_d = work_q;
        if (cs_rise && (work_q != CNT_MAX)) begin
            work_d = work_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            sel_q      <= 2'b10;
            tmr_q      <= '0;
            work_q     <= '0;
            sat_work_q <= 1'b0;
            sat_q      <= 1'b0;
            oe_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sync_q     <= 3'b000;
            for (int i = 0; i < 4; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            sync_q <= {sync_q[1:0], cs_out};
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= SETUP;
                        idx_q      <= 2'd0;
                        sel_q      <= filt_code(2'd0);
                        busy_q     <= 1'b1;
                        oe_q       <= 1'b0;
                        sat_work_q <= 1'b0;
                    end
                end
                SETUP: begin
                    tmr_q   <= '0;
                    work_q  <= '0;
                    state_q <= (SETTLE_CYC == 0) ? COUNT : SETTLE;
                end
                SETTLE: begin
                    if (tmr_q == SETTLE_LAST) begin
                        tmr_q   <= '0;
                        state_q <= COUNT;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                COUNT: begin
                    work_q     <= work_d;
                    sat_work_q <= sat_work_q | ovf;
                    if (tmr_q == WIN_LAST) begin
                        // work_d folds in an edge landing on the final window cycle.
                        res_q[idx_q] <= work_d;
                        if (idx_q == 2'd3) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            sel_q   <= filt_code(idx_q + 2'd1);
                            state_q <= SETUP;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    sat_q   <= sat_work_q;
                    busy_q  <= 1'b0;
                    oe_q    <= 1'b1;
                    sel_q   <= 2'b10;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign S0          = 1'b1;
    assign S1          = 1'b0;
    assign S2          = sel_q[1];
    assign S3          = sel_q[0];
    assign OE          = oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sat         = sat_q;
    assign red_cnt     = res_q[0];
    assign blue_cnt    = res_q[1];
    assign green_cnt   = res_q[2];
    assign clear_cnt   = res_q[3];
    assign state_dbg_o = state_q;

endmodule
